// File: rtl/ddr_bank_arbiter.sv
// ddr_bank_arbiter: burst-atomic K/D arbiter for one DDR4 EMIF bank; define DDR_ARB_KERNEL_PRIO_EN for fixed K priority
`timescale 1ns/1ps
module ddr_bank_arbiter #(
  parameter int DATA_W = 512,
  parameter int BE_W = DATA_W/8,
  parameter int ADDR_W = 32,
  parameter int BURST_W = 5,
  parameter int TAG_DEPTH = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [ADDR_W-1:0]  k_address,
  input  logic [BURST_W-1:0] k_burstcount,
  input  logic               k_read,
  input  logic               k_write,
  input  logic [DATA_W-1:0]  k_writedata,
  input  logic [BE_W-1:0]    k_byteenable,
  output logic               k_waitrequest,
  output logic [DATA_W-1:0]  k_readdata,
  output logic               k_readdatavalid,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BURST_W-1:0] d_burstcount,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [DATA_W-1:0]  d_writedata,
  input  logic [BE_W-1:0]    d_byteenable,
  output logic               d_waitrequest,
  output logic [DATA_W-1:0]  d_readdata,
  output logic               d_readdatavalid,
  output logic [ADDR_W-1:0]  emif_address,
  output logic [BURST_W-1:0] emif_burstcount,
  output logic               emif_read,
  output logic               emif_write,
  output logic [DATA_W-1:0]  emif_writedata,
  output logic [BE_W-1:0]    emif_byteenable,
  input  logic               emif_waitrequest,
  input  logic [DATA_W-1:0]  emif_readdata,
  input  logic               emif_readdatavalid,
  output logic               orphan_rsp_err
);
  localparam int PW = $clog2(TAG_DEPTH);
  typedef enum logic [1:0] {IDLE, OWN_K, OWN_D} state_t;
  state_t state, state_nx;
  logic last_d, last_d_nx;
  logic [BURST_W-1:0] wr_left, wr_nx, rsp_cnt;
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic tag_d [TAG_DEPTH];
  logic [BURST_W-1:0] tag_bc [TAG_DEPTH];
  logic own_k, own_d, own, k_ask, d_ask, tag_full, tag_empty;
  logic rd_acc, wr_acc, wr_done, push, pop, rsp_hit;
  assign own_k = state == OWN_K;
  assign own_d = state == OWN_D;
  assign own = own_k | own_d;
  assign k_ask = k_read | k_write;
  assign d_ask = d_read | d_write;
  assign tag_full = cnt == (PW+1)'(TAG_DEPTH);
  assign tag_empty = cnt == '0;
  assign emif_address = own_d ? d_address : k_address;
  assign emif_burstcount = own_d ? d_burstcount : k_burstcount;
  assign emif_writedata = own_d ? d_writedata : k_writedata;
  assign emif_byteenable = own_d ? d_byteenable : k_byteenable;
  assign emif_read = own & ~tag_full & (own_d ? d_read : k_read);
  assign emif_write = own & (own_d ? d_write : k_write);
  assign k_waitrequest = own_k ? emif_waitrequest | (k_read & tag_full) : 1'b1;
  assign d_waitrequest = own_d ? emif_waitrequest | (d_read & tag_full) : 1'b1;
  assign rd_acc = emif_read & ~emif_waitrequest;
  assign wr_acc = emif_write & ~emif_waitrequest;
  assign wr_nx = (wr_left == '0 ? emif_burstcount : wr_left) - 1'b1;
  assign wr_done = wr_acc & (wr_nx == '0);
  assign push = rd_acc;
  assign rsp_hit = emif_readdatavalid & ~tag_empty;
  assign pop = rsp_hit & (rsp_cnt + 1'b1 == tag_bc[rp]);
  assign k_readdatavalid = rsp_hit & ~tag_d[rp];
  assign d_readdatavalid = rsp_hit & tag_d[rp];
  assign k_readdata = k_readdatavalid ? emif_readdata : '0;
  assign d_readdata = d_readdatavalid ? emif_readdata : '0;
  // Grant in IDLE; release ownership once the read command or last write beat is accepted
  always_comb begin
    state_nx = state;
    last_d_nx = last_d;
    if (state == IDLE) begin
`ifdef DDR_ARB_KERNEL_PRIO_EN
      state_nx = k_ask ? OWN_K : d_ask ? OWN_D : IDLE;
`else
      state_nx = (k_ask & d_ask) ? (last_d ? OWN_K : OWN_D) : k_ask ? OWN_K : d_ask ? OWN_D : IDLE;
`endif
    end else if (rd_acc | wr_done) begin
      state_nx = IDLE;
      last_d_nx = own_d;
    end
  end
  // Arbiter state, write beat counter and orphan flag
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state <= IDLE;
      last_d <= 1'b1;
      wr_left <= '0;
      orphan_rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      last_d <= last_d_nx;
      if (wr_acc & ~rd_acc) wr_left <= wr_nx;
      if (emif_readdatavalid & tag_empty) orphan_rsp_err <= 1'b1;
    end
  // Tag FIFO pointers, occupancy and head beat counter
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (rsp_hit) rsp_cnt <= pop ? '0 : rsp_cnt + 1'b1;
    end
  // Tag FIFO storage: owner and beat count per outstanding read
  always_ff @(posedge clk_clk)
    if (push) begin
      tag_d[wp] <= own_d;
      tag_bc[wp] <= emif_burstcount;
    end
endmodule
